axi_lite_gpio: RTL and testbench
================================

Name: axi_lite_gpio

Overview:
- Single-channel, 32-bit general-purpose I/O peripheral with an AXI4-Lite slave register interface. Register map follows the Xilinx AXI GPIO channel-1 layout.
- Sits behind an AXI4-Lite master (CPU interconnect or traffic generator).
- Drives output pins and per-bit tristate enables; samples input pins through a synchronizer.
- Raises a level interrupt on any input change.

Parameters:
- GPIO_WIDTH, 32, number of GPIO bits (1..32); register bits above GPIO_WIDTH read 0 and ignore writes.
- ADDR_WIDTH, 9, AXI address width in bits.
- DOUT_DEFAULT, 32'h0, reset value of the DATA output register.
- TRI_DEFAULT, 32'hFFFF_FFFF, reset value of the TRI register (1 = input).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata  in  32; s_axi_wstrb  in  4; s_axi_wvalid  in  1; s_axi_wready  out  1.
- s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1.
- s_axi_araddr  in  ADDR_WIDTH; s_axi_arvalid  in  1; s_axi_arready  out  1.
- s_axi_rdata  out  32; s_axi_rresp  out  2; s_axi_rvalid  out  1; s_axi_rready  in  1.
- gpio_io_i  in  GPIO_WIDTH  pin inputs.
- gpio_io_o  out  GPIO_WIDTH  pin output values (= DATA register).
- gpio_io_t  out  GPIO_WIDTH  tristate enables (= TRI register; 1 = pin is input).
- ip2intc_irpt  out  1  level interrupt.

Behaviour:
- Reset (rst=1 at posedge): all ready/valid outputs 0; bresp=rresp=00; rdata=0; DATA=DOUT_DEFAULT; TRI=TRI_DEFAULT; GIER=0; IER=0; ISR=0; synchronizer flops=0; ip2intc_irpt=0. A reset mid-transaction drops any pending B or R response.
- Register map (address bits [8:2] decode, bits [1:0] ignored):
  - 0x000 DATA (RW).
  - 0x004 TRI (RW).
  - 0x11C GIER (bit31 only, RW).
  - 0x120 ISR (bit0, read; write 1 to clear).
  - 0x128 IER (bit0, RW).
  - Other offsets read 0; writes to them are discarded. All responses are OKAY (00); no SLVERR is ever returned.
- Input sync: gpio_io_i passes through a 2-flop synchronizer, giving gpio_sync 2 cycles after the pin changes.
- DATA read value = (gpio_sync AND TRI) OR (DATA_reg AND NOT TRI), per bit.
- Write channel:
  - A write is accepted when awvalid && wvalid && !bvalid. awready and wready pulse high together for exactly that one cycle; AW and W are never accepted separately.
  - The register updates at the same edge, byte lanes gated by wstrb.
  - bvalid rises the next cycle and holds until bready. A new write is not accepted while bvalid=1.
- Read channel:
  - A read is accepted when arvalid && !rvalid; arready pulses for one cycle.
  - rvalid and rdata are registered the next cycle (1-cycle latency). rdata is held stable until rready; no new read is accepted meanwhile.
- Simultaneous read and write: both are accepted in the same cycle. A read of the register being written returns the pre-write value.
- Interrupt:
  - Set condition: gpio_sync differs from its previous-cycle value while IER[0]=1. ISR[0] is set at that edge.
  - A write of 1 to ISR[0] clears it. If a set and a clear occur in the same cycle, set wins.
  - ip2intc_irpt = GIER[31] & IER[0] & ISR[0], registered.

Test Plan:
- Hold gpio_io_i=32'h5 through reset, release, wait 3 cycles, read 0x000 -> rdata=32'h0000_0005, rresp=00, rvalid exactly 1 cycle after arready. Check that gpio_io_t=32'hFFFF_FFFF and gpio_io_o=0 after reset.
- Write TRI=0x0000_0000, then DATA=0x0000_00A5 with wstrb=4'hF -> gpio_io_t=0, gpio_io_o=0xA5, read 0x000 returns 0xA5, bresp=00.
- Write DATA=0xFFFF_FFFF with wstrb=4'b0100 (starting from 0xA5) -> DATA=0x00FF_00A5.
- Set TRI=0x0000_FFFF, DATA=0x1234_5678, gpio_io_i=0xAAAA_BBBB -> read 0x000 returns 0x1234_BBBB.
- Hold bready=0 for 5 cycles after a write -> bvalid stays 1, awready stays 0 for a second queued write; accept it only after bready. Read unmapped offset 0x040 -> 0, OKAY.
- Write GIER=0x8000_0000, IER=1, then toggle gpio_io_i bit0 -> ISR[0]=1 and irq=1 within 4 cycles. Write ISR=1 -> irq=0 next cycle. Assert rst mid-read -> rvalid=0 at the next edge.

Source files
------------

// File: rtl/axi_lite_gpio.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_lite_gpio : single-channel AXI4-Lite GPIO with change IRQ    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module axi_lite_gpio #(
  parameter int          GPIO_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 9,
  parameter logic [31:0] DOUT_DEFAULT = 32'h0,
  parameter logic [31:0] TRI_DEFAULT  = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [GPIO_WIDTH-1:0] gpio_io_i,
  output logic [GPIO_WIDTH-1:0] gpio_io_o,
  output logic [GPIO_WIDTH-1:0] gpio_io_t,
  output logic                  ip2intc_irpt
);

  localparam logic [6:0]  c_off_data = 7'h00;
  localparam logic [6:0]  c_off_tri  = 7'h01;
  localparam logic [6:0]  c_off_gier = 7'h47;
  localparam logic [6:0]  c_off_isr  = 7'h48;
  localparam logic [6:0]  c_off_ier  = 7'h4A;
  localparam logic [31:0] c_gpio_mask =
    (GPIO_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'h1 << GPIO_WIDTH) - 32'h1);

  logic [31:0]           data_q, data_d;
  logic [31:0]           tri_q, tri_d;
  logic                  gier_q, gier_d;
  logic                  ier_q, ier_d;
  logic                  isr_q, isr_d;
  logic                  irq_q, irq_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
  logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;
  logic [GPIO_WIDTH-1:0] sync_prev_q, sync_prev_d;

  logic        w_wr_en;
  logic        w_rd_en;
  logic [6:0]  w_wr_sel;
  logic [6:0]  w_rd_sel;
  logic [31:0] w_in_ext;
  logic [31:0] w_rd_val;
  logic        w_isr_set;
  logic        w_isr_clr;
  logic [3:0]  w_unused_addr;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // Handshakes are suppressed during reset so no transfer is seen as accepted.
  always_comb begin
    w_wr_en       = !rst && s_axi_awvalid && s_axi_wvalid && !bvalid_q;
    w_rd_en       = !rst && s_axi_arvalid && !rvalid_q;
    w_wr_sel      = s_axi_awaddr[8:2];
    w_rd_sel      = s_axi_araddr[8:2];
    w_unused_addr = {s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  end

  // Pins configured as inputs read back the synchronised value.
  always_comb begin
    w_in_ext                   = '0;
    w_in_ext[GPIO_WIDTH-1:0]   = sync2_q;
    case (w_rd_sel)
      c_off_data: w_rd_val = (w_in_ext & tri_q) | (data_q & ~tri_q);
      c_off_tri:  w_rd_val = tri_q;
      c_off_gier: w_rd_val = {gier_q, 31'b0};
      c_off_isr:  w_rd_val = {31'b0, isr_q};
      c_off_ier:  w_rd_val = {31'b0, ier_q};
      default:    w_rd_val = 32'h0;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    tri_d     = tri_q;
    gier_d    = gier_q;
    ier_d     = ier_q;
    w_isr_clr = 1'b0;
    if (w_wr_en) begin
      case (w_wr_sel)
        c_off_data: data_d = merge_strb(data_q, s_axi_wdata, s_axi_wstrb) & c_gpio_mask;
        c_off_tri:  tri_d  = merge_strb(tri_q, s_axi_wdata, s_axi_wstrb) & c_gpio_mask;
        c_off_gier: if (s_axi_wstrb[3]) gier_d = s_axi_wdata[31];
        c_off_isr:  w_isr_clr = s_axi_wstrb[0] & s_axi_wdata[0];
        c_off_ier:  if (s_axi_wstrb[0]) ier_d = s_axi_wdata[0];
        default:    ;
      endcase
    end

    sync1_d     = gpio_io_i;
    sync2_d     = sync1_q;
    sync_prev_d = sync2_q;

    // A fresh input change outranks a simultaneous software clear.
    w_isr_set = ier_q && (sync2_q != sync_prev_q);
    isr_d     = w_isr_set | (isr_q & ~w_isr_clr);
    irq_d     = gier_d & ier_d & isr_d;

    bvalid_d = w_wr_en ? 1'b1 : (s_axi_bready ? 1'b0 : bvalid_q);
    rvalid_d = w_rd_en ? 1'b1 : (s_axi_rready ? 1'b0 : rvalid_q);
    rdata_d  = w_rd_en ? w_rd_val : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= DOUT_DEFAULT & c_gpio_mask;
      tri_q       <= TRI_DEFAULT & c_gpio_mask;
      gier_q      <= 1'b0;
      ier_q       <= 1'b0;
      isr_q       <= 1'b0;
      irq_q       <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_prev_q <= '0;
    end else begin
      data_q      <= data_d;
      tri_q       <= tri_d;
      gier_q      <= gier_d;
      ier_q       <= ier_d;
      isr_q       <= isr_d;
      irq_q       <= irq_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_prev_q <= sync_prev_d;
    end
  end

  assign s_axi_awready = w_wr_en;
  assign s_axi_wready  = w_wr_en;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = w_rd_en;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign gpio_io_o     = data_q[GPIO_WIDTH-1:0];
  assign gpio_io_t     = tri_q[GPIO_WIDTH-1:0];
  assign ip2intc_irpt  = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_gpio.sv
`default_nettype none
// tb_axi_lite_gpio : vector table, hand sequences and random traffic checked
// against a register-level model of the GPIO.
module tb_axi_lite_gpio;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] gpio_io_i, gpio_io_o, gpio_io_t;
  logic        irq;

  always #5 clk = ~clk;

  axi_lite_gpio dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .gpio_io_i(gpio_io_i), .gpio_io_o(gpio_io_o), .gpio_io_t(gpio_io_t),
    .ip2intc_irpt(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_data, m_tri, m_pins;
  logic        m_gier, m_ier, m_isr;

  typedef struct {
    logic [31:0] pins;
    logic [8:0]  waddr;
    logic [31:0] wdat;
    logic [3:0]  wstb;
    logic [8:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[13];
  logic [8:0]  alist[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 32'h0; m_tri = 32'hFFFF_FFFF;
    m_gier = 1'b0; m_ier = 1'b0; m_isr = 1'b0;
  endtask

  task automatic model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    case ({a[8:2], 2'b00})
      9'h000: for (int b = 0; b < 4; b++) if (s[b]) m_data[8*b +: 8] = d[8*b +: 8];
      9'h004: for (int b = 0; b < 4; b++) if (s[b]) m_tri[8*b +: 8] = d[8*b +: 8];
      9'h11C: if (s[3]) m_gier = d[31];
      9'h120: if (s[0] && d[0]) m_isr = 1'b0;
      9'h128: if (s[0]) m_ier = d[0];
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [8:0] a);
    case ({a[8:2], 2'b00})
      9'h000:  return (m_pins & m_tri) | (m_data & ~m_tri);
      9'h004:  return m_tri;
      9'h11C:  return {m_gier, 31'b0};
      9'h120:  return {31'b0, m_isr};
      9'h128:  return {31'b0, m_ier};
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_pins(input logic [31:0] v);
    if (m_ier && v != m_pins) m_isr = 1'b1;
    gpio_io_i = v;
    m_pins    = v;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    chk("wr_awready", 32'(awready), 32'h1);
    chk("wr_wready", 32'(wready), 32'h1);
    @(posedge clk);
    model_write(a, d, s);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", 32'(bvalid), 32'h1);
    chk("wr_bresp", 32'(bresp), 32'h0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("wr_bvalid_drop", 32'(bvalid), 32'h0);
  endtask

  task automatic axi_read(input logic [8:0] a, output logic [31:0] d);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    #1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    chk("rd_arready", 32'(arready), 32'h1);
    chk("rd_rvalid_pre", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_rresp", 32'(rresp), 32'h0);
    d = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rd_rvalid_drop", 32'(rvalid), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old_v;
    logic [8:0]  ra;

    tbl[0]  = '{32'h0000_0005,     9'h004, 32'h0000_0000, 4'hF, 9'h004, 32'h0000_0000};
    tbl[1]  = '{32'h0000_0005,     9'h000, 32'h0000_00A5, 4'hF, 9'h000, 32'h0000_00A5};
    tbl[2]  = '{32'h0000_0005,     9'h000, 32'hFFFF_FFFF, 4'h4, 9'h000, 32'h00FF_00A5};
    tbl[3]  = '{32'hAAAA_BBBB,     9'h004, 32'h0000_FFFF, 4'hF, 9'h004, 32'h0000_FFFF};
    tbl[4]  = '{32'hAAAA_BBBB,     9'h000, 32'h1234_5678, 4'hF, 9'h000, 32'h1234_BBBB};
    tbl[5]  = '{32'hAAAA_BBBB,     9'h040, 32'hDEAD_BEEF, 4'hF, 9'h040, 32'h0000_0000};
    tbl[6]  = '{32'hAAAA_BBBB,     9'h11C, 32'hFFFF_FFFF, 4'hF, 9'h11C, 32'h8000_0000};
    tbl[7]  = '{32'hAAAA_BBBB,     9'h11C, 32'h0000_0000, 4'h7, 9'h11C, 32'h8000_0000};
    tbl[8]  = '{32'hAAAA_BBBB,     9'h11C, 32'h0000_0000, 4'hF, 9'h11C, 32'h0000_0000};
    tbl[9]  = '{32'hAAAA_BBBB,     9'h128, 32'hFFFF_FFFE, 4'hF, 9'h128, 32'h0000_0000};
    tbl[10] = '{32'hAAAA_BBBB,     9'h004, 32'hFFFF_FFFF, 4'h8, 9'h004, 32'hFF00_FFFF};
    tbl[11] = '{32'hAAAA_BBBB,     9'h1FC, 32'h0000_0000, 4'hF, 9'h002, 32'hAA34_BBBB};
    tbl[12] = '{32'hAAAA_BBBB,     9'h120, 32'h0000_0001, 4'hF, 9'h120, 32'h0000_0000};
    alist = '{9'h000, 9'h004, 9'h11C, 9'h120, 9'h128, 9'h040, 9'h1FC, 9'h006};

    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    gpio_io_i = 32'h5; m_pins = 32'h5;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_t", gpio_io_t, 32'hFFFF_FFFF);
    chk("rst_gpio_o", gpio_io_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_valids", {30'b0, bvalid, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    axi_read(9'h000, rd);
    chk("first_read", rd, 32'h0000_0005);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].pins != m_pins) set_pins(tbl[i].pins);
      axi_write(tbl[i].waddr, tbl[i].wdat, tbl[i].wstb);
      axi_read(tbl[i].raddr, rd);
      chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
      chk($sformatf("tbl%0d_o", i), gpio_io_o, m_data);
      chk($sformatf("tbl%0d_t", i), gpio_io_t, m_tri);
    end

    // Back-pressure: second write must wait for bready.
    awaddr = 9'h000; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    chk("bp_first_ready", 32'(awready), 32'h1);
    @(posedge clk);
    model_write(9'h000, 32'h11, 4'hF);
    #1;
    wdata = 32'h22;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid_hold", 32'(bvalid), 32'h1);
      chk("bp_awready_low", 32'(awready), 32'h0);
      @(posedge clk); #1;
    end
    chk("bp_data_first", gpio_io_o, 32'h11);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bp_bvalid_drop", 32'(bvalid), 32'h0);
    chk("bp_second_ready", 32'(awready), 32'h1);
    @(posedge clk);
    model_write(9'h000, 32'h22, 4'hF);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_bvalid2", 32'(bvalid), 32'h1);
    chk("bp_data_second", gpio_io_o, 32'h22);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;

    // Concurrent read and write of TRI returns the old value.
    old_v = m_tri;
    awaddr = 9'h004; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 9'h004; arvalid = 1'b1;
    #1;
    chk("rw_both_ready", {30'b0, awready, arready}, 32'h3);
    @(posedge clk);
    model_write(9'h004, 32'h0F0F_0F0F, 4'hF);
    #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("rw_rdata_old", rdata, old_v);
    chk("rw_valids", {30'b0, bvalid, rvalid}, 32'h3);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    chk("rw_gpio_t_new", gpio_io_t, 32'h0F0F_0F0F);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: axi_write(9'h000, $urandom, 4'($urandom_range(0, 15)));
        1: axi_write(9'h004, $urandom, 4'($urandom_range(0, 15)));
        2: set_pins($urandom);
        3: begin
          ra = alist[$urandom_range(0, 7)];
          axi_read(ra, rd);
          chk($sformatf("rand_rd_%h", ra), rd, model_read(ra));
        end
        default: axi_write(9'h11C, $urandom, 4'hF);
      endcase
      chk("rand_o", gpio_io_o, m_data);
      chk("rand_t", gpio_io_t, m_tri);
    end

    axi_write(9'h11C, 32'h8000_0000, 4'hF);
    axi_write(9'h128, 32'h1, 4'hF);
    chk("irq_idle", 32'(irq), 32'h0);
    set_pins(m_pins ^ 32'h1);
    chk("irq_rise", 32'(irq), 32'h1);
    axi_read(9'h120, rd);
    chk("isr_set", rd, model_read(9'h120));
    axi_write(9'h120, 32'h1, 4'hF);
    chk("irq_cleared", 32'(irq), 32'h0);
    axi_read(9'h120, rd);
    chk("isr_cleared", rd, 32'h0);
    set_pins(m_pins ^ 32'h8000_0000);
    chk("irq_rise2", 32'(irq), 32'h1);
    axi_write(9'h11C, 32'h0, 4'hF);
    chk("irq_gier_off", 32'(irq), 32'h0);
    axi_read(9'h120, rd);
    chk("isr_still_set", rd, 32'h1);

    // Reset with both a B and an R response pending.
    awaddr = 9'h000; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 9'h000; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("mid_pending", {30'b0, bvalid, rvalid}, 32'h3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valids", {30'b0, bvalid, rvalid}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_t", gpio_io_t, 32'hFFFF_FFFF);
    chk("mid_rst_o", gpio_io_o, 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    axi_read(9'h000, rd);
    chk("post_rst_data", rd, model_read(9'h000));
    axi_read(9'h120, rd);
    chk("post_rst_isr", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
